bitonic_stream_out: RTL and testbench
=====================================

# bitonic_stream_out

Output unloader for the bitonic sorting pipeline. Captures each sorted vector presented in parallel by the final merge stage (single-cycle `valid_in` pulse, no backpressure), and replays it one element per beat on a valid/ready stream toward downstream consumers. Two vector slots (active + pending) absorb back-to-back sorter results while the consumer stalls. Drops are flagged, never silent.

## Interface
- `DEPTH`, 8: elements per vector; power of two, ≥2
- `WIDTH`, 32: bits per element
- `REVERSE`, 0: 0 = emit index 0 first; 1 = emit index DEPTH-1 first
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `valid_in`  in  1  one-cycle pulse: `seq_in` holds a sorted vector
- `seq_in`  in  WIDTH × [DEPTH-1:0]  unpacked array, same shape as sorter `seq_out`
- `in_ready`  out  1  advisory: pending slot free, so a `valid_in` next cycle will not drop
- `out_data`  out  WIDTH  current element
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts beat when `out_valid && out_ready`
- `out_last`  out  1  current beat is the final element of the vector
- `out_index`  out  $clog2(DEPTH)  array index of current element
- `overflow`  out  1  sticky; set when a vector is dropped; cleared only by `rst`

## Operation
- Two states: IDLE (active slot empty), STREAM (active slot loaded, `out_valid`=1).
- Slots: `active` (vector + beat counter `cnt`) and `pending` (vector + full flag).
- IDLE + `valid_in`: load `seq_in` into active, `cnt`=0, go to STREAM.
- STREAM + `valid_in`:
  - pending empty: store in pending.
  - pending full and the final beat handshakes this cycle: pending moves to active, `seq_in` goes into pending, no drop.
  - pending full otherwise: drop the vector, set `overflow`.
- Beat handshake (`out_valid && out_ready`): `cnt`++.
- Final beat handshake (`cnt`=DEPTH-1):
  - pending full: pending → active, `cnt`=0, stay STREAM.
  - pending empty: go to IDLE, unless `valid_in` is high this cycle, in which case load active directly and stay STREAM.
- `out_index` = `cnt` if REVERSE=0, else DEPTH-1-`cnt`. `out_data` = `active[out_index]`.
- `out_last` = STREAM && `cnt`==DEPTH-1.
- `out_data`, `out_index` and `out_last` are driven from registered state only. `out_data` is held stable while `out_valid && !out_ready`.
- `in_ready` = !pending_full. It is registered-state-derived, with no combinational path from `valid_in` or `out_ready`.
- In IDLE, `out_data` and `out_index` are 0.
- Values are passed through unmodified. No arithmetic is performed on the data.

## Timing
- Reset values: state IDLE, both slots cleared, `cnt`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `out_index`=0, `overflow`=0, `in_ready`=1.
- Latency: `valid_in` at edge t gives first beat with `out_valid`=1 after edge t; it is visible in cycle t+1.
- Throughput: one element per cycle with `out_ready` held high.
- Back-to-back vectors stream with no bubble between the last beat and the next first beat.
- Reset mid-stream: the next cycle shows reset values. Both in-flight vectors are discarded and `overflow` is cleared.
- A `valid_in` on the same cycle as `rst` is ignored.

## Structure
- Add to shared `bitonic_pkg`:
  - state enum `stream_state_t` {IDLE, STREAM}
  - `localparam`-style function `idx_w(depth)` returning $clog2(depth)
- Single module. No sub-module is warranted; the slot storage and counter stay inline.

## Test plan
Config for all scenarios: DEPTH=4, WIDTH=8, REVERSE=0 unless noted.
- **Basic:** `valid_in` with `seq_in`={3,7,9,12} (index 0..3), `out_ready`=1.
  - Cycles t+1..t+4: `out_data` 3,7,9,12; `out_index` 0..3.
  - `out_last` high only at t+4; IDLE at t+5.
- **Reverse:** same vector with REVERSE=1.
  - Emits 12,9,7,3 with `out_index` 3,2,1,0.
- **Backpressure:** toggle `out_ready` 1,0,0,1,… during a stream.
  - `out_data` holds during stalls; exactly 4 beats delivered; no duplicates.
- **Back-to-back:** vectors A={1,2,3,4} then B={5,6,7,8} one cycle apart, `out_ready`=1.
  - 8 contiguous beats 1..8; `in_ready` low while B is pending.
- **Overflow:** `out_ready`=0, then three `valid_in` pulses.
  - First two vectors are retained and the third is dropped.
  - `overflow`=1 from the cycle after the third pulse.
  - After release: exactly 8 beats, the first two vectors in order.
- **Boundary handoff and reset:**
  - Pending full; `valid_in` coincides with the final-beat handshake → no overflow, and the new vector streams third.
  - `rst` asserted mid-vector → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/bitonic_pkg.sv
// Shared types and helpers for the bitonic sorting pipeline.
package bitonic_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/bitonic_stream_out.sv
// Unloads parallel sorted vectors onto a one-element-per-beat valid/ready stream,
// with an active slot being replayed and one pending slot to absorb bursts.
module bitonic_stream_out
    import bitonic_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 32,
    parameter bit REVERSE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [WIDTH-1:0]         seq_in [DEPTH-1:0],
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH)-1:0] out_index,
    output logic                     overflow
);

    localparam int IW = idx_w(DEPTH);
    localparam logic [IW-1:0] LAST_CNT = IW'(DEPTH - 1);

    stream_state_t   state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic            pend_full_q, pend_full_d;
    logic            overflow_q, overflow_d;
    logic [WIDTH-1:0] active_q [DEPTH-1:0];
    logic [WIDTH-1:0] active_d [DEPTH-1:0];
    logic [WIDTH-1:0] pend_q   [DEPTH-1:0];
    logic [WIDTH-1:0] pend_d   [DEPTH-1:0];

    logic          streaming;
    logic          beat_hs;
    logic          last_hs;
    logic [IW-1:0] idx;

    assign streaming = (state_q == STREAM);
    assign beat_hs   = streaming && out_ready;
    assign last_hs   = beat_hs && (cnt_q == LAST_CNT);
    assign idx       = REVERSE ? (LAST_CNT - cnt_q) : cnt_q;

    // Outputs come only from registered state; IDLE forces data/index to zero.
    assign out_valid = streaming;
    assign out_last  = streaming && (cnt_q == LAST_CNT);
    assign out_index = streaming ? idx : '0;
    assign out_data  = streaming ? active_q[idx] : '0;
    assign in_ready  = !pend_full_q;
    assign overflow  = overflow_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_full_d = pend_full_q;
        overflow_d  = overflow_q;
        active_d    = active_q;
        pend_d      = pend_q;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    active_d = seq_in;
                    cnt_d    = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (last_hs) begin
                    cnt_d = '0;
                    if (pend_full_q) begin
                        active_d = pend_q;
                        if (valid_in) begin
                            pend_d = seq_in;
                        end else begin
                            pend_full_d = 1'b0;
                        end
                    end else if (valid_in) begin
                        active_d = seq_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (beat_hs) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Pending slot full and no slot freeing this cycle: the vector is lost.
                    if (valid_in) begin
                        if (!pend_full_q) begin
                            pend_d      = seq_in;
                            pend_full_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_full_q <= pend_full_d;
            overflow_q  <= overflow_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    active_q[gi] <= '0;
                    pend_q[gi]   <= '0;
                end else begin
                    active_q[gi] <= active_d[gi];
                    pend_q[gi]   <= pend_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_bitonic_stream_out.sv
// Directed table-driven bench for bitonic_stream_out (DEPTH=4, WIDTH=8).
module tb_bitonic_stream_out;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic [7:0] seq_in [3:0];
    logic       out_ready;

    logic       in_ready, out_valid, out_last, overflow;
    logic [7:0] out_data;
    logic [1:0] out_index;
    logic       r_in_ready, r_out_valid, r_out_last, r_overflow;
    logic [7:0] r_out_data;
    logic [1:0] r_out_index;

    always #5 clk = ~clk;

    bitonic_stream_out #(.DEPTH(4), .WIDTH(8), .REVERSE(1'b0)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .seq_in(seq_in),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_index(out_index),
        .overflow(overflow)
    );

    bitonic_stream_out #(.DEPTH(4), .WIDTH(8), .REVERSE(1'b1)) dut_rev (
        .clk(clk), .rst(rst), .valid_in(valid_in), .seq_in(seq_in),
        .in_ready(r_in_ready), .out_data(r_out_data), .out_valid(r_out_valid),
        .out_ready(out_ready), .out_last(r_out_last), .out_index(r_out_index),
        .overflow(r_overflow)
    );

    typedef struct packed {
        logic            en;
        logic            rst;
        logic            vld;
        logic [3:0][7:0] seq;
        logic            rdy;
        logic            ev;
        logic [7:0]      ed;
        logic [1:0]      ei;
        logic            el;
        logic            eir;
        logic            eov;
        logic            rchk;
        logic [7:0]      erd;
        logic [1:0]      eri;
    } vec_t;

    localparam logic [3:0][7:0] Z  = '0;
    localparam logic [3:0][7:0] VA = {8'd12, 8'd9, 8'd7, 8'd3};
    localparam logic [3:0][7:0] V1 = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [3:0][7:0] V2 = {8'd8, 8'd7, 8'd6, 8'd5};
    localparam logic [3:0][7:0] V3 = {8'd12, 8'd11, 8'd10, 8'd9};

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic rs();
        vec_t r;
        r = '0;
        r.rst = 1'b1;
        tbl.push_back(r);
    endtask

    task automatic idl(input logic v, input logic [3:0][7:0] s, input logic rdy,
                       input logic eir, input logic eov);
        vec_t r;
        r = '0;
        r.en = 1'b1; r.vld = v; r.seq = s; r.rdy = rdy; r.eir = eir; r.eov = eov;
        tbl.push_back(r);
    endtask

    task automatic bt(input logic v, input logic [3:0][7:0] s, input logic rdy,
                      input logic [7:0] ed, input logic [1:0] ei, input logic el,
                      input logic eir, input logic eov);
        vec_t r;
        r = '0;
        r.en = 1'b1; r.vld = v; r.seq = s; r.rdy = rdy; r.ev = 1'b1;
        r.ed = ed; r.ei = ei; r.el = el; r.eir = eir; r.eov = eov;
        tbl.push_back(r);
    endtask

    task automatic rv(input logic [7:0] erd, input logic [1:0] eri);
        vec_t r;
        r = tbl.pop_back();
        r.rchk = 1'b1; r.erd = erd; r.eri = eri;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0][7:0] s, input logic rdy);
        rst = r; valid_in = v; out_ready = rdy;
        for (int k = 0; k < 4; k++) seq_in[k] = s[k];
    endtask

    task automatic check_idle(input int row, input logic eov);
        check("valid", row, 32'(out_valid), 32'd0);
        check("data", row, 32'(out_data), 32'd0);
        check("index", row, 32'(out_index), 32'd0);
        check("last", row, 32'(out_last), 32'd0);
        check("in_ready", row, 32'(in_ready), 32'd1);
        check("overflow", row, 32'(overflow), 32'(eov));
    endtask

    initial begin
        int   waited;
        vec_t r;
        drive(1'b1, 1'b0, Z, 1'b0);

        // Basic stream, reverse instance checked alongside
        rs();
        idl(1, VA, 1, 1, 0);           rv(0, 0);
        bt(0, Z, 1, 3, 0, 0, 1, 0);    rv(12, 3);
        bt(0, Z, 1, 7, 1, 0, 1, 0);    rv(9, 2);
        bt(0, Z, 1, 9, 2, 0, 1, 0);    rv(7, 1);
        bt(0, Z, 1, 12, 3, 1, 1, 0);   rv(3, 0);
        idl(0, Z, 1, 1, 0);            rv(0, 0);
        // Backpressure 1,0,0,1,...
        rs();
        idl(1, VA, 1, 1, 0);
        bt(0, Z, 1, 3, 0, 0, 1, 0);
        bt(0, Z, 0, 7, 1, 0, 1, 0);
        bt(0, Z, 0, 7, 1, 0, 1, 0);
        bt(0, Z, 1, 7, 1, 0, 1, 0);
        bt(0, Z, 1, 9, 2, 0, 1, 0);
        bt(0, Z, 0, 12, 3, 1, 1, 0);
        bt(0, Z, 0, 12, 3, 1, 1, 0);
        bt(0, Z, 1, 12, 3, 1, 1, 0);
        idl(0, Z, 1, 1, 0);
        // Back-to-back A then B
        rs();
        idl(1, V1, 1, 1, 0);
        bt(1, V2, 1, 1, 0, 0, 1, 0);
        bt(0, Z, 1, 2, 1, 0, 0, 0);
        bt(0, Z, 1, 3, 2, 0, 0, 0);
        bt(0, Z, 1, 4, 3, 1, 0, 0);
        bt(0, Z, 1, 5, 0, 0, 1, 0);
        bt(0, Z, 1, 6, 1, 0, 1, 0);
        bt(0, Z, 1, 7, 2, 0, 1, 0);
        bt(0, Z, 1, 8, 3, 1, 1, 0);
        idl(0, Z, 1, 1, 0);
        // Overflow: third vector dropped while stalled
        rs();
        idl(1, V1, 0, 1, 0);
        bt(1, V2, 0, 1, 0, 0, 1, 0);
        bt(1, V3, 0, 1, 0, 0, 0, 0);
        bt(0, Z, 0, 1, 0, 0, 0, 1);
        bt(0, Z, 1, 1, 0, 0, 0, 1);
        bt(0, Z, 1, 2, 1, 0, 0, 1);
        bt(0, Z, 1, 3, 2, 0, 0, 1);
        bt(0, Z, 1, 4, 3, 1, 0, 1);
        bt(0, Z, 1, 5, 0, 0, 1, 1);
        bt(0, Z, 1, 6, 1, 0, 1, 1);
        bt(0, Z, 1, 7, 2, 0, 1, 1);
        bt(0, Z, 1, 8, 3, 1, 1, 1);
        idl(0, Z, 1, 1, 1);
        // Pending full, valid_in on final-beat handshake: no drop, C streams third
        rs();
        idl(1, V1, 1, 1, 0);
        bt(1, V2, 1, 1, 0, 0, 1, 0);
        bt(0, Z, 1, 2, 1, 0, 0, 0);
        bt(0, Z, 1, 3, 2, 0, 0, 0);
        bt(1, V3, 1, 4, 3, 1, 0, 0);
        bt(0, Z, 1, 5, 0, 0, 0, 0);
        bt(0, Z, 1, 6, 1, 0, 0, 0);
        bt(0, Z, 1, 7, 2, 0, 0, 0);
        bt(0, Z, 1, 8, 3, 1, 0, 0);
        bt(0, Z, 1, 9, 0, 0, 1, 0);
        bt(0, Z, 1, 10, 1, 0, 1, 0);
        bt(0, Z, 1, 11, 2, 0, 1, 0);
        bt(0, Z, 1, 12, 3, 1, 1, 0);
        idl(0, Z, 1, 1, 0);
        // Pending empty, valid_in on final beat loads active directly
        rs();
        idl(1, V1, 1, 1, 0);
        bt(0, Z, 1, 1, 0, 0, 1, 0);
        bt(0, Z, 1, 2, 1, 0, 1, 0);
        bt(0, Z, 1, 3, 2, 0, 1, 0);
        bt(1, V2, 1, 4, 3, 1, 1, 0);
        bt(0, Z, 1, 5, 0, 0, 1, 0);
        bt(0, Z, 1, 6, 1, 0, 1, 0);
        bt(0, Z, 1, 7, 2, 0, 1, 0);
        bt(0, Z, 1, 8, 3, 1, 1, 0);
        idl(0, Z, 1, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i];
            @(negedge clk);
            drive(r.rst, r.vld, r.seq, r.rdy);
            if (r.en) begin
                check("valid", i, 32'(out_valid), 32'(r.ev));
                check("data", i, 32'(out_data), 32'(r.ed));
                check("index", i, 32'(out_index), 32'(r.ei));
                check("last", i, 32'(out_last), 32'(r.el));
                check("in_ready", i, 32'(in_ready), 32'(r.eir));
                check("overflow", i, 32'(overflow), 32'(r.eov));
            end
            if (r.rchk) begin
                check("rev_valid", i, 32'(r_out_valid), 32'(r.ev));
                check("rev_data", i, 32'(r_out_data), 32'(r.erd));
                check("rev_index", i, 32'(r_out_index), 32'(r.eri));
                check("rev_last", i, 32'(r_out_last), 32'(r.el));
                check("rev_in_ready", i, 32'(r_in_ready), 32'(r.eir));
                check("rev_overflow", i, 32'(r_overflow), 32'(r.eov));
            end
        end

        // Reset mid-vector with overflow set and a coincident valid_in
        @(negedge clk); drive(1'b1, 1'b0, Z, 1'b0);
        @(negedge clk); drive(1'b0, 1'b1, V1, 1'b0);
        @(negedge clk); drive(1'b0, 1'b1, V2, 1'b0);
        @(negedge clk); drive(1'b0, 1'b1, V3, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, Z, 1'b1);
        check("pre_rst_overflow", 1000, 32'(overflow), 32'd1);
        @(negedge clk);
        @(negedge clk); drive(1'b1, 1'b1, V3, 1'b1);
        check("pre_rst_data", 1001, 32'(out_data), 32'd3);
        @(negedge clk); drive(1'b0, 1'b0, Z, 1'b1);
        check_idle(1002, 1'b0);
        @(negedge clk);
        check_idle(1003, 1'b0);

        // Latency: first beat visible the cycle after valid_in, bounded wait
        drive(1'b0, 1'b1, VA, 1'b1);
        @(negedge clk); drive(1'b0, 1'b0, Z, 1'b1);
        waited = 1;
        while (!out_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("latency", 1004, 32'(waited), 32'd1);
        check("first_data", 1005, 32'(out_data), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
